// File: rtl/hop_rst_seq_driver.sv
// Reset-sequence driver for the hop reset-chain benchmark: releases stage resets in
// order, fires start into the chain and measures the loopback latency on ff6_in.
module hop_rst_seq_driver #(
    parameter int HOLD_CYC  = 8,
    parameter int STAGE_GAP = 4,
    parameter int EXP_LAT   = 6,
    parameter int TIMEOUT   = 32,
    parameter int LAT_W     = 8
) (
    input  logic             clock0,
    input  logic             rst1,
    input  logic             go,
    input  logic             ff6_in,
    output logic             rst2,
    output logic             rst3,
    output logic             rst4,
    output logic             rst5,
    output logic             start,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic [LAT_W-1:0] latency
);

    localparam int REL_CYC = 4 * STAGE_GAP;
    localparam int TMAX    = (HOLD_CYC > REL_CYC) ? HOLD_CYC : REL_CYC;
    localparam int TW      = $clog2(TMAX + 1);

    localparam logic [TW-1:0]    HOLD_LAST   = TW'(HOLD_CYC - 1);
    localparam logic [TW-1:0]    REL_LAST    = TW'(REL_CYC - 1);
    localparam logic [TW-1:0]    GAP1        = TW'(STAGE_GAP);
    localparam logic [TW-1:0]    GAP2        = TW'(2 * STAGE_GAP);
    localparam logic [TW-1:0]    GAP3        = TW'(3 * STAGE_GAP);
    localparam logic [TW-1:0]    TMR_ONE     = TW'(1);
    localparam logic [LAT_W-1:0] LAT_EXP     = LAT_W'(EXP_LAT);
    localparam logic [LAT_W-1:0] LAT_TO      = LAT_W'(TIMEOUT);
    localparam logic [LAT_W-1:0] LAT_TO_LAST = LAT_W'(TIMEOUT - 1);
    localparam logic [LAT_W-1:0] LAT_ONE     = LAT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HOLD   = 3'd1,
        S_REL    = 3'd2,
        S_FIRE   = 3'd3,
        S_REPORT = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [TW-1:0]    tmr_q, tmr_d, tmr_inc_s;
    logic [LAT_W-1:0] cnt_q, cnt_d;
    logic [LAT_W-1:0] lat_q, lat_d;
    logic [3:0]       stg_q, stg_d;     // bit 0 drives rst2 ... bit 3 drives rst5
    logic             start_q, start_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             fail_q, fail_d;

    function automatic logic lat_match(input logic [LAT_W-1:0] cnt);
        return (cnt == LAT_EXP);
    endfunction

    // Next-state and next-output logic for the release/fire/report sequence
    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q;
        cnt_d     = cnt_q;
        lat_d     = lat_q;
        stg_d     = stg_q;
        start_d   = start_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        pass_d    = pass_q;
        fail_d    = fail_q;
        tmr_inc_s = tmr_q + TMR_ONE;

        case (state_q)
            S_IDLE: begin
                stg_d   = 4'b1111;
                start_d = 1'b0;
                busy_d  = 1'b0;
                if (go) begin
                    state_d = S_HOLD;
                    busy_d  = 1'b1;
                    pass_d  = 1'b0;
                    fail_d  = 1'b0;
                    lat_d   = '0;
                    tmr_d   = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_HOLD: begin
                if (tmr_q == HOLD_LAST) begin
                    state_d  = S_REL;
                    stg_d[0] = 1'b0;
                    tmr_d    = '0;
                end else begin
                    tmr_d = tmr_inc_s;
                end
            end

            S_REL: begin
                if (tmr_q == REL_LAST) begin
                    // A chain output already high before start is driven means it is stuck.
                    if (ff6_in) begin
                        state_d = S_REPORT;
                        done_d  = 1'b1;
                        pass_d  = 1'b0;
                        fail_d  = 1'b1;
                        lat_d   = '0;
                        stg_d   = 4'b1111;
                        start_d = 1'b0;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = S_FIRE;
                        start_d = 1'b1;
                        cnt_d   = '0;
                    end
                end else begin
                    tmr_d    = tmr_inc_s;
                    stg_d[1] = stg_q[1] & (tmr_inc_s < GAP1);
                    stg_d[2] = stg_q[2] & (tmr_inc_s < GAP2);
                    stg_d[3] = stg_q[3] & (tmr_inc_s < GAP3);
                end
            end

            S_FIRE: begin
                start_d = 1'b1;
                if (ff6_in) begin
                    state_d = S_REPORT;
                    done_d  = 1'b1;
                    lat_d   = cnt_q;
                    pass_d  = lat_match(cnt_q);
                    fail_d  = ~lat_match(cnt_q);
                    stg_d   = 4'b1111;
                    start_d = 1'b0;
                    busy_d  = 1'b0;
                end else if (cnt_q == LAT_TO_LAST) begin
                    state_d = S_REPORT;
                    done_d  = 1'b1;
                    cnt_d   = LAT_TO;
                    lat_d   = LAT_TO;
                    pass_d  = 1'b0;
                    fail_d  = 1'b1;
                    stg_d   = 4'b1111;
                    start_d = 1'b0;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + LAT_ONE;
                end
            end

            S_REPORT: begin
                state_d = S_IDLE;
                stg_d   = 4'b1111;
                start_d = 1'b0;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = S_IDLE;
                stg_d   = 4'b1111;
                start_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; rst1 forces the chain back into reset immediately
    always_ff @(posedge clock0 or posedge rst1) begin
        if (rst1) begin
            state_q <= S_IDLE;
            tmr_q   <= '0;
            cnt_q   <= '0;
            lat_q   <= '0;
            stg_q   <= 4'b1111;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            cnt_q   <= cnt_d;
            lat_q   <= lat_d;
            stg_q   <= stg_d;
            start_q <= start_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
        end
    end

    assign rst2    = stg_q[0];
    assign rst3    = stg_q[1];
    assign rst4    = stg_q[2];
    assign rst5    = stg_q[3];
    assign start   = start_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign pass    = pass_q;
    assign fail    = fail_q;
    assign latency = lat_q;

endmodule

// File: tb/tb_hop_rst_seq_driver.sv
// Bench for hop_rst_seq_driver: a behavioural flop-chain loopback, a table of fixed
// scenarios, hand sequences for retrigger / mid-run reset, and randomized runs.
module tb_hop_rst_seq_driver;

    localparam int H    = 8;
    localparam int GAP  = 4;
    localparam int EL   = 6;
    localparam int TO   = 32;
    localparam int LW   = 8;
    localparam int FOFF = H + 4 * GAP;

    logic          clock0 = 1'b0;
    logic          rst1;
    logic          go;
    logic          ff6_in;
    logic          rst2, rst3, rst4, rst5, start, busy, done, pass, fail;
    logic [LW-1:0] latency;

    logic [63:0] chain;
    int          mode  = 0;   // 0: chain of 'depth' flops, 1: tied 0, 2: tied 1
    int          depth = 6;
    int          edge_cnt = 0;
    int          total = 0;
    int          bad   = 0;

    typedef struct {
        int m;
        int d;
        int lat;
        bit p;
        bit f;
        int ek;
    } vec_t;

    vec_t vt[7];

    hop_rst_seq_driver #(
        .HOLD_CYC (H),
        .STAGE_GAP(GAP),
        .EXP_LAT  (EL),
        .TIMEOUT  (TO),
        .LAT_W    (LW)
    ) dut (
        .clock0 (clock0),
        .rst1   (rst1),
        .go     (go),
        .ff6_in (ff6_in),
        .rst2   (rst2),
        .rst3   (rst3),
        .rst4   (rst4),
        .rst5   (rst5),
        .start  (start),
        .busy   (busy),
        .done   (done),
        .pass   (pass),
        .fail   (fail),
        .latency(latency)
    );

    always #5 clock0 = ~clock0;

    always @(posedge clock0) edge_cnt <= edge_cnt + 1;

    // Downstream chain model, held clear while its first stage reset is asserted
    always @(posedge clock0 or posedge rst1) begin
        if (rst1) chain <= '0;
        else if (rst2) chain <= '0;
        else chain <= {chain[62:0], start};
    end

    always_comb begin
        if (mode == 1) ff6_in = 1'b0;
        else if (mode == 2) ff6_in = 1'b1;
        else ff6_in = chain[depth-1];
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference: cycle (relative to the go edge) at which done is expected
    function automatic int model_done_k(input int m, input int d);
        if (m == 2) return FOFF;
        if (m == 1) return FOFF + TO;
        return FOFF + ((d >= TO) ? TO : d + 1);
    endfunction

    function automatic int model_lat(input int m, input int d);
        if (m == 2) return 0;
        if (m == 1) return TO;
        return (d >= TO) ? TO : d;
    endfunction

    // Caller is at a negedge; go is sampled at the next edge (k=0)
    task automatic run_seq(input int m, input int d, input int lat_e, input bit p_e,
                           input bit f_e, input int e_k, input bit noisy);
        logic [6:0]    sig_e;
        logic [LW+1:0] res_e;
        logic [31:0]   lat_v;
        mode  = m;
        depth = d;
        lat_v = lat_e;
        go    = 1'b1;
        for (int k = 0; k <= e_k + 3; k++) begin
            @(negedge clock0);
            go = noisy && (k == 2 || k == 3 || k == FOFF + 2) && (k < e_k);
            sig_e[0] = (k == e_k);
            sig_e[1] = (k < e_k);
            sig_e[2] = (k >= FOFF) && (k < e_k);
            sig_e[3] = !((k >= H) && (k < e_k));
            sig_e[4] = !((k >= H + GAP) && (k < e_k));
            sig_e[5] = !((k >= H + 2 * GAP) && (k < e_k));
            sig_e[6] = !((k >= H + 3 * GAP) && (k < e_k));
            check("seq_ctrl", {25'd0, rst5, rst4, rst3, rst2, start, busy, done}, {25'd0, sig_e});
            res_e = (k >= e_k) ? {p_e, f_e, lat_v[LW-1:0]} : '0;
            check("seq_result", {22'd0, pass, fail, latency}, {22'd0, res_e});
        end
        go = 1'b0;
    endtask

    initial begin
        int m, d, j;
        bit pe;

        vt[0] = '{0, 6, 6, 1'b1, 1'b0, 31};
        vt[1] = '{0, 7, 7, 1'b0, 1'b1, 32};
        vt[2] = '{1, 1, 32, 1'b0, 1'b1, 56};
        vt[3] = '{2, 1, 0, 1'b0, 1'b1, 24};
        vt[4] = '{0, 31, 31, 1'b0, 1'b1, 56};
        vt[5] = '{0, 32, 32, 1'b0, 1'b1, 56};
        vt[6] = '{0, 1, 1, 1'b0, 1'b1, 26};

        rst1 = 1'b1;
        go   = 1'b0;
        @(negedge clock0);
        check("reset_ctrl", {25'd0, rst5, rst4, rst3, rst2, start, busy, done}, 32'h78);
        check("reset_result", {22'd0, pass, fail, latency}, 32'd0);
        @(negedge clock0);
        rst1 = 1'b0;

        // Scenario 1 aligned so go is sampled at edge 10
        while (edge_cnt < 9) @(negedge clock0);
        run_seq(vt[0].m, vt[0].d, vt[0].lat, vt[0].p, vt[0].f, vt[0].ek, 1'b0);

        for (int i = 1; i < 7; i++) begin
            repeat (2) @(negedge clock0);
            run_seq(vt[i].m, vt[i].d, vt[i].lat, vt[i].p, vt[i].f, vt[i].ek, 1'b0);
        end

        // Stray go pulses during HOLD and FIRE must be ignored
        run_seq(0, 6, 6, 1'b1, 1'b0, 31, 1'b1);

        // go held high re-triggers from IDLE right after REPORT
        mode = 0;
        depth = 6;
        go = 1'b1;
        for (int k = 0; k <= 32; k++) begin
            @(negedge clock0);
            if (k == 31) check("retrig_done", {31'd0, done}, 32'd1);
            if (k == 32) check("retrig_idle_busy", {31'd0, busy}, 32'd0);
        end
        @(negedge clock0);
        check("retrig_busy", {31'd0, busy}, 32'd1);
        go = 1'b0;
        j = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clock0);
            if (done && j < 0) j = k;
        end
        check("retrig_done_k", j, 32'd31);
        check("retrig_result", {22'd0, pass, fail, latency}, {22'd0, 1'b1, 1'b0, 8'd6});

        // rst1 mid-FIRE takes effect without a clock edge, and no done follows
        go = 1'b1;
        @(negedge clock0);
        go = 1'b0;
        repeat (27) @(negedge clock0);
        check("midfire_start", {31'd0, start}, 32'd1);
        #2 rst1 = 1'b1;
        #1;
        check("midrst_ctrl", {25'd0, rst5, rst4, rst3, rst2, start, busy, done}, 32'h78);
        check("midrst_result", {22'd0, pass, fail, latency}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clock0);
            check("midrst_nodone", {31'd0, done}, 32'd0);
        end
        rst1 = 1'b0;
        repeat (2) @(negedge clock0);
        check("post_rst_nodone", {31'd0, done}, 32'd0);
        run_seq(vt[0].m, vt[0].d, vt[0].lat, vt[0].p, vt[0].f, vt[0].ek, 1'b0);

        // Randomized loopback depth / mode against the timeline model
        for (int i = 0; i < 12; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clock0);
            m  = ($urandom_range(0, 9) < 7) ? 0 : int'($urandom_range(1, 2));
            d  = $urandom_range(1, 40);
            pe = (m == 0) && (d == EL);
            run_seq(m, d, model_lat(m, d), pe, !pe, model_done_k(m, d), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
